// File: rtl/count_err.sv
// 4-bit free-running up-counter exposing its current and previous value, with an
// optional injected sequencing fault at a chosen count (skip, hold or step back).
module count_err #(
  parameter int unsigned ERR_EN   = 1,
  parameter logic [3:0]  ERR_AT   = 4'd5,
  parameter int unsigned ERR_MODE = 0
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] count,
  output logic [3:0] prevcount
);

  localparam logic [3:0] AtPlus1 = ERR_AT + 4'd1;

  logic [3:0] r_count;
  logic [3:0] r_prevcount;
  // Set by a step-back fault so the immediate re-entry into ERR_AT steps normally.
  logic       r_back;

  logic       w_at;
  logic       w_fire;
  logic [3:0] w_count_next;
  logic       w_back_next;

  assign w_at = (r_count == ERR_AT);

  always_comb begin
    w_fire = 1'b0;
    if (ERR_EN != 0) begin
      case (ERR_MODE)
        1:       w_fire = w_at && (r_prevcount != r_count);
        2:       w_fire = w_at && !r_back && (r_prevcount != AtPlus1);
        default: w_fire = w_at;
      endcase
    end
  end

  always_comb begin
    w_count_next = r_count + 4'd1;
    if (w_fire) begin
      case (ERR_MODE)
        1:       w_count_next = r_count;
        2:       w_count_next = r_count - 4'd1;
        default: w_count_next = r_count + 4'd2;
      endcase
    end
  end

  always_comb begin
    w_back_next = 1'b0;
    if (ERR_MODE == 2) begin
      if (w_fire) begin
        w_back_next = 1'b1;
      end else if (w_at) begin
        w_back_next = 1'b0;
      end else begin
        w_back_next = r_back;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count     <= 4'h0;
      r_prevcount <= 4'hF;
      r_back      <= 1'b0;
    end else begin
      r_count     <= w_count_next;
      r_prevcount <= r_count;
      r_back      <= w_back_next;
    end
  end

  assign count     = r_count;
  assign prevcount = r_prevcount;

endmodule

// File: tb/tb_count_err.sv
// Directed bench for count_err: five parameterisations sampled on the falling edge
// against hand-computed count tables, plus mid-count and held reset.
module tb_count_err;

  logic clk;
  logic rst;

  logic [3:0] cnt_free, prv_free;
  logic [3:0] cnt_m0, prv_m0;
  logic [3:0] cnt_m1, prv_m1;
  logic [3:0] cnt_m2, prv_m2;
  logic [3:0] cnt_wr, prv_wr;

  int checks;
  int errors;

  count_err #(.ERR_EN(0), .ERR_AT(4'd5), .ERR_MODE(0)) u_free (
    .clk(clk), .rst(rst), .count(cnt_free), .prevcount(prv_free));
  count_err #(.ERR_EN(1), .ERR_AT(4'd5), .ERR_MODE(0)) u_m0 (
    .clk(clk), .rst(rst), .count(cnt_m0), .prevcount(prv_m0));
  count_err #(.ERR_EN(1), .ERR_AT(4'd5), .ERR_MODE(1)) u_m1 (
    .clk(clk), .rst(rst), .count(cnt_m1), .prevcount(prv_m1));
  count_err #(.ERR_EN(1), .ERR_AT(4'd5), .ERR_MODE(2)) u_m2 (
    .clk(clk), .rst(rst), .count(cnt_m2), .prevcount(prv_m2));
  count_err #(.ERR_EN(1), .ERR_AT(4'd15), .ERR_MODE(0)) u_wr (
    .clk(clk), .rst(rst), .count(cnt_wr), .prevcount(prv_wr));

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Expected count at the k-th falling edge after reset (k = 0 is the reset sample).
  logic [3:0] e_free [20];
  logic [3:0] e_m0   [20];
  logic [3:0] e_m1   [20];
  logic [3:0] e_m2   [20];
  logic [3:0] e_wr   [20];

  int bad_free, bad_m0, bad_m1, bad_m2, bad_wr;

  function automatic bit seq_bad(input logic [3:0] c, input logic [3:0] p);
    logic [3:0] pp;
    pp = p + 4'd1;
    return c != pp;
  endfunction

  initial begin
    logic [3:0] exp_prev;
    bit         hit;
    e_free = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
               4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3};
    e_m0   = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7, 4'd8, 4'd9, 4'd10,
               4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    e_m1   = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd5, 4'd6, 4'd7, 4'd8,
               4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2};
    e_m2   = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd4, 4'd5, 4'd6, 4'd7,
               4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1};
    e_wr   = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9,
               4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd1, 4'd2, 4'd3, 4'd4};
    checks = 0;
    errors = 0;
    bad_free = 0; bad_m0 = 0; bad_m1 = 0; bad_m2 = 0; bad_wr = 0;

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      check_eq($sformatf("free_cnt[%0d]", k), cnt_free, e_free[k]);
      check_eq($sformatf("m0_cnt[%0d]", k), cnt_m0, e_m0[k]);
      check_eq($sformatf("m1_cnt[%0d]", k), cnt_m1, e_m1[k]);
      check_eq($sformatf("m2_cnt[%0d]", k), cnt_m2, e_m2[k]);
      check_eq($sformatf("wr_cnt[%0d]", k), cnt_wr, e_wr[k]);
      exp_prev = (k == 0) ? 4'hF : e_free[k-1];
      check_eq($sformatf("free_prv[%0d]", k), prv_free, exp_prev);
      exp_prev = (k == 0) ? 4'hF : e_m0[k-1];
      check_eq($sformatf("m0_prv[%0d]", k), prv_m0, exp_prev);
      exp_prev = (k == 0) ? 4'hF : e_m1[k-1];
      check_eq($sformatf("m1_prv[%0d]", k), prv_m1, exp_prev);
      exp_prev = (k == 0) ? 4'hF : e_m2[k-1];
      check_eq($sformatf("m2_prv[%0d]", k), prv_m2, exp_prev);
      exp_prev = (k == 0) ? 4'hF : e_wr[k-1];
      check_eq($sformatf("wr_prv[%0d]", k), prv_wr, exp_prev);
      bad_free += int'(seq_bad(cnt_free, prv_free));
      bad_m0   += int'(seq_bad(cnt_m0, prv_m0));
      bad_m1   += int'(seq_bad(cnt_m1, prv_m1));
      bad_m2   += int'(seq_bad(cnt_m2, prv_m2));
      bad_wr   += int'(seq_bad(cnt_wr, prv_wr));
    end
    check_eq("free_bad_samples", bad_free, 0);
    check_eq("m0_bad_samples", bad_m0, 1);
    check_eq("m1_bad_samples", bad_m1, 1);
    check_eq("m2_bad_samples", bad_m2, 1);
    check_eq("wr_bad_samples", bad_wr, 1);

    // Run the fault-free counter to 9, then reset mid-count.
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (cnt_free == 4'd9) hit = 1'b1;
    end
    check_eq("reach_nine", int'(hit), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_cnt", cnt_free, 0);
    check_eq("midrst_prv", prv_free, 15);
    check_eq("midrst_m2_cnt", cnt_m2, 0);
    check_eq("midrst_m2_prv", prv_m2, 15);
    @(negedge clk);
    check_eq("after_rst_cnt", cnt_free, 1);
    check_eq("after_rst_prv", prv_free, 0);
    check_eq("after_rst_m1_cnt", cnt_m1, 1);

    // Held reset keeps 0/F.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq($sformatf("hold_rst_cnt[%0d]", i), cnt_m0, 0);
      check_eq($sformatf("hold_rst_prv[%0d]", i), prv_m0, 15);
    end
    rst = 1'b0;
    @(negedge clk);
    check_eq("release_cnt", cnt_wr, 1);
    check_eq("release_prv", prv_wr, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
